// File: rtl/conv_output_writer_pkg.sv
// Shared configuration, result record and requantization helpers for the
// convolution output writer.
package conv_output_writer_pkg;

    typedef struct packed {
        int unsigned io_data_width;
        int unsigned accumulation_width;
        int unsigned feature_map_width;
        int unsigned feature_map_height;
        int unsigned output_nb_channels;
        int unsigned fifo_depth;
    } config_t;

    localparam config_t CFG = '{
        io_data_width:      16,
        accumulation_width: 32,
        feature_map_width:  128,
        feature_map_height: 128,
        output_nb_channels: 16,
        fifo_depth:         8
    };

    localparam int IO_W       = int'(CFG.io_data_width);
    localparam int ACC_W      = int'(CFG.accumulation_width);
    localparam int X_W        = $clog2(CFG.feature_map_width);
    localparam int Y_W        = $clog2(CFG.feature_map_height);
    localparam int CH_W       = $clog2(CFG.output_nb_channels);
    localparam int ADDR_W     = X_W + Y_W + CH_W;
    localparam int FIFO_DEPTH = int'(CFG.fifo_depth);
    localparam int SHIFT_W    = 5;

    typedef struct packed {
        logic [IO_W-1:0]   data;
        logic [ADDR_W-1:0] addr;
    } result_t;

    // Saturation bounds expressed at the widened accumulator width.
    localparam logic signed [ACC_W:0] SAT_HI =
        $signed((ACC_W+1)'((64'd1 << (IO_W-1)) - 64'd1));
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    function automatic logic [IO_W-1:0] sat_io(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] c;
        c = v;
        if (v > SAT_HI) c = SAT_HI;
        if (v < SAT_LO) c = SAT_LO;
        return c[IO_W-1:0];
    endfunction

    function automatic logic [IO_W-1:0] requant(input logic [ACC_W-1:0]   acc,
                                                input logic [SHIFT_W-1:0] shift,
                                                input logic               relu);
        logic signed [ACC_W:0] v;
        logic [ACC_W:0]        rnd;
        v = (relu && acc[ACC_W-1]) ? '0 : $signed({acc[ACC_W-1], acc});
        if (shift != '0) begin
            rnd = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
            v   = v + $signed(rnd);
            v   = v >>> shift;
        end
        return sat_io(v);
    endfunction

endpackage

// File: rtl/conv_output_writer_if.sv
// Memory write port: head-of-FIFO result with a valid/ready handshake.
interface conv_output_writer_if;
    import conv_output_writer_pkg::*;

    logic [IO_W-1:0]   wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_valid;
    logic              wr_ready;

    modport master (output wr_data, output wr_addr, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_addr, input wr_valid, output wr_ready);

endinterface

// File: rtl/conv_output_writer_adder.sv
// Plain two-operand adder shared across the datapath.
module conv_output_writer_adder #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/conv_output_writer_out_result_fifo.sv
// Synchronous result FIFO; head is visible combinationally, a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module out_result_fifo
    import conv_output_writer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    arst_n,
    input  logic    clear,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    result_t       mem [DEPTH];

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !clear;
        do_push  = push && (!full || do_pop) && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/conv_output_writer.sv
// Captures conv results, requantizes them into a stage register and drains them
// through a small FIFO to the memory write port; overflow is flagged, never stalled.
module conv_output_writer
    import conv_output_writer_pkg::*;
(
    input  logic               clk,
    input  logic               arst_n_in,
    input  logic               clear,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic               relu_en,
    input  logic [ACC_W-1:0]   in_data,
    input  logic               in_valid,
    input  logic [X_W-1:0]     in_x,
    input  logic [Y_W-1:0]     in_y,
    input  logic [CH_W-1:0]    in_ch,
    conv_output_writer_if.master wr,
    output logic               overflow,
    output logic               empty,
    output logic [31:0]        words_written
);
    logic                  stage_valid_q, stage_valid_d;
    result_t               stage_res_q, stage_res_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           words_written_q, words_written_d;

    logic signed [ACC_W:0] relu_v;
    logic [ACC_W:0]        round_c;
    logic [ACC_W:0]        round_sum;
    logic signed [ACC_W:0] shifted;

    result_t               fifo_head;
    logic                  fifo_full, fifo_empty;
    logic                  pop_fire, drop;

    always_comb begin
        relu_v  = (relu_en && in_data[ACC_W-1]) ? '0 : $signed({in_data[ACC_W-1], in_data});
        round_c = (shift_amount == '0) ? '0
                                       : ((ACC_W+1)'(1) << (shift_amount - SHIFT_W'(1)));
    end

    conv_output_writer_adder #(.W(ACC_W+1)) u_round_add (
        .a   (relu_v),
        .b   (round_c),
        .sum (round_sum)
    );

    assign shifted = $signed(round_sum) >>> shift_amount;

    out_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n_in),
        .clear     (clear),
        .push      (stage_valid_q),
        .push_data (stage_res_q),
        .pop       (wr.wr_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        pop_fire = wr.wr_valid && wr.wr_ready && !clear;
        // A staged result is lost only if the FIFO is full and nothing leaves it.
        drop     = stage_valid_q && fifo_full && !pop_fire && !clear;

        stage_valid_d   = in_valid && !clear;
        stage_res_d     = stage_res_q;
        if (in_valid) begin
            stage_res_d.data = sat_io(shifted);
            stage_res_d.addr = {in_y, in_x, in_ch};
        end

        overflow_d      = clear ? 1'b0 : (overflow_q || drop);
        words_written_d = clear ? 32'd0 : (words_written_q + 32'(pop_fire));
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stage_valid_q   <= 1'b0;
            stage_res_q     <= '0;
            overflow_q      <= 1'b0;
            words_written_q <= '0;
        end else begin
            stage_valid_q   <= stage_valid_d;
            stage_res_q     <= stage_res_d;
            overflow_q      <= overflow_d;
            words_written_q <= words_written_d;
        end
    end

    assign wr.wr_valid   = !fifo_empty;
    assign wr.wr_data    = fifo_empty ? '0 : fifo_head.data;
    assign wr.wr_addr    = fifo_empty ? '0 : fifo_head.addr;
    assign overflow      = overflow_q;
    assign empty         = !stage_valid_q && fifo_empty;
    assign words_written = words_written_q;

endmodule
